// File: rtl/snoop_bus_ctrl.sv
// Shared snoop-bus sequencer: captures the arbiter winner, broadcasts, waits for a response, returns done.
// Latency: grant -> bus_valid 1 cycle; rsp_valid -> done 1 cycle; minimum 4 cycles IDLE-to-IDLE.
// Backpressure: none; gnt is only sampled in IDLE, so the owner holds the bus until done.
module snoop_bus_ctrl #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int N_AGENT = 5,
    parameter int TIMEOUT = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_AGENT-1:0]        gnt,
    input  logic [2*N_AGENT-1:0]      req_cmd,
    input  logic [ADDR_W*N_AGENT-1:0] req_addr,
    input  logic [DATA_W*N_AGENT-1:0] req_wdata,
    output logic                      bus_valid,
    output logic [1:0]                bus_cmd,
    output logic [ADDR_W-1:0]         bus_addr,
    output logic [DATA_W-1:0]         bus_wdata,
    output logic [2:0]                bus_src,
    output logic                      busy,
    input  logic                      rsp_valid,
    input  logic [DATA_W-1:0]         rsp_data,
    output logic [N_AGENT-1:0]        done,
    output logic [DATA_W-1:0]         done_data,
    output logic                      err
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BCAST = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_FIN   = 2'd3;

    localparam int CW = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    logic [1:0]         state;
    logic [CW-1:0]      cnt;
    logic [2:0]         owner;
    logic               multi_hot;
    logic [N_AGENT-1:0] src_onehot;

    // Lowest-index set bit wins, so a malformed multi-hot grant still has a deterministic owner.
    always_comb begin
        owner = 3'd0;
        for (int i = N_AGENT - 1; i >= 0; i--) begin
            if (gnt[i]) begin
                owner = 3'(i);
            end
        end
    end

    assign multi_hot  = |(gnt & (gnt - N_AGENT'(1)));
    assign src_onehot = N_AGENT'(1) << bus_src;
    assign busy       = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            bus_valid <= 1'b0;
            bus_cmd   <= 2'b00;
            bus_addr  <= '0;
            bus_wdata <= '0;
            bus_src   <= 3'd0;
            done      <= '0;
            done_data <= '0;
            err       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= '0;
                    err  <= 1'b0;
                    if (|gnt) begin
                        bus_cmd   <= req_cmd[2*owner +: 2];
                        bus_addr  <= req_addr[ADDR_W*owner +: ADDR_W];
                        bus_wdata <= req_wdata[DATA_W*owner +: DATA_W];
                        bus_src   <= owner;
                        bus_valid <= 1'b1;
                        err       <= multi_hot;
                        state     <= S_BCAST;
                    end
                end
                S_BCAST: begin
                    bus_valid <= 1'b0;
                    err       <= 1'b0;
                    cnt       <= '0;
                    state     <= S_WAIT;
                end
                S_WAIT: begin
                    cnt <= cnt + CW'(1);
                    if (rsp_valid) begin
                        done_data <= rsp_data;
                        done      <= src_onehot;
                        state     <= S_FIN;
                    end else if (cnt == CNT_LAST) begin
                        done_data <= '0;
                        done      <= src_onehot;
                        err       <= 1'b1;
                        state     <= S_FIN;
                    end
                end
                S_FIN: begin
                    done  <= '0;
                    err   <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_snoop_bus_ctrl.sv
// Scoreboard bench for snoop_bus_ctrl: expected broadcasts and completions are queued as stimulus is driven.
module tb_snoop_bus_ctrl;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NA = 5;
    localparam int TO = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [NA-1:0]     gnt;
    logic [2*NA-1:0]   req_cmd;
    logic [AW*NA-1:0]  req_addr;
    logic [DW*NA-1:0]  req_wdata;
    logic              bus_valid;
    logic [1:0]        bus_cmd;
    logic [AW-1:0]     bus_addr;
    logic [DW-1:0]     bus_wdata;
    logic [2:0]        bus_src;
    logic              busy;
    logic              rsp_valid;
    logic [DW-1:0]     rsp_data;
    logic [NA-1:0]     done;
    logic [DW-1:0]     done_data;
    logic              err;

    typedef struct {
        logic [1:0]    cmd;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [2:0]    src;
        logic          err;
    } bexp_t;

    typedef struct {
        logic [NA-1:0] done;
        logic [DW-1:0] data;
        logic          err;
    } dexp_t;

    bexp_t bcast_q[$];
    dexp_t done_q[$];

    int n_chk  = 0;
    int n_fail = 0;
    int n_done = 0;

    snoop_bus_ctrl #(.ADDR_W(AW), .DATA_W(DW), .N_AGENT(NA), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .gnt(gnt), .req_cmd(req_cmd), .req_addr(req_addr),
        .req_wdata(req_wdata), .bus_valid(bus_valid), .bus_cmd(bus_cmd),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_src(bus_src), .busy(busy),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .done(done),
        .done_data(done_data), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Outputs are registered; sampling on the falling edge keeps clear of input updates.
    always @(negedge clk) begin
        if (bus_valid === 1'b1) begin
            if (bcast_q.size() == 0) begin
                check("bus_valid_unexpected", 1, 0);
            end else begin
                bexp_t b;
                b = bcast_q.pop_front();
                check("bus_cmd", 64'(bus_cmd), 64'(b.cmd));
                check("bus_addr", 64'(bus_addr), 64'(b.addr));
                check("bus_wdata", 64'(bus_wdata), 64'(b.wdata));
                check("bus_src", 64'(bus_src), 64'(b.src));
                check("bcast_err", 64'(err), 64'(b.err));
            end
        end
        if (done !== '0 && done !== 'x) begin
            n_done++;
            if (done_q.size() == 0) begin
                check("done_unexpected", 64'(done), 0);
            end else begin
                dexp_t d;
                d = done_q.pop_front();
                check("done", 64'(done), 64'(d.done));
                check("done_data", 64'(done_data), 64'(d.data));
                check("done_err", 64'(err), 64'(d.err));
            end
        end
        if (err === 1'b1 && bus_valid !== 1'b1 && done === '0) begin
            check("err_stray", 1, 0);
        end
    end

    task automatic set_req(input int a, input logic [1:0] c, input logic [AW-1:0] ad,
                           input logic [DW-1:0] wd);
        req_cmd[2*a +: 2]     = c;
        req_addr[AW*a +: AW]  = ad;
        req_wdata[DW*a +: DW] = wd;
    endtask

    // Grant and queue expectations; returns with the DUT in its first WAIT cycle.
    task automatic start_txn(input logic [NA-1:0] g, input int own, input logic mh,
                             input logic [DW-1:0] dexp, input logic terr);
        bexp_t b;
        dexp_t d;
        b.cmd   = req_cmd[2*own +: 2];
        b.addr  = req_addr[AW*own +: AW];
        b.wdata = req_wdata[DW*own +: DW];
        b.src   = 3'(own);
        b.err   = mh;
        bcast_q.push_back(b);
        d.done = NA'(1) << own;
        d.data = dexp;
        d.err  = terr;
        done_q.push_back(d);
        gnt = g;
        tick();
        gnt = '0;
        tick();
    endtask

    task automatic respond(input int wait_cyc, input logic [DW-1:0] data);
        repeat (wait_cyc) tick();
        rsp_valid = 1'b1;
        rsp_data  = data;
        tick();
        rsp_valid = 1'b0;
        rsp_data  = '0;
        check("busy_in_fin", 64'(busy), 1);
        tick();
        check("busy_after", 64'(busy), 0);
    endtask

    initial begin
        rst = 1'b1; gnt = '0; req_cmd = '0; req_addr = '0; req_wdata = '0;
        rsp_valid = 1'b0; rsp_data = '0;
        repeat (2) tick();
        rst = 1'b0;
        check("rst_bus_valid", 64'(bus_valid), 0);
        check("rst_busy", 64'(busy), 0);
        check("rst_done", 64'(done), 0);
        check("rst_err", 64'(err), 0);
        check("rst_bus_src", 64'(bus_src), 0);
        check("rst_done_data", 64'(done_data), 0);

        // 1: basic BusRdX from agent 2; stray response while idle is ignored
        rsp_valid = 1'b1; rsp_data = 32'hBAD0; tick(); rsp_valid = 1'b0;
        check("idle_rsp_ignored", 64'(busy), 0);
        set_req(2, 2'b01, 32'h40, 32'h0);
        start_txn(5'b00100, 2, 1'b0, 32'hDEAD, 1'b0);
        respond(1, 32'hDEAD);

        // 2: timeout on agent 0 after exactly TO WAIT cycles
        set_req(0, 2'b00, 32'h1000, 32'h0);
        start_txn(5'b00001, 0, 1'b0, 32'h0, 1'b0);
        done_q[done_q.size()-1].err = 1'b1;
        repeat (TO - 1) tick();
        check("to_not_yet_done", 64'(done), 0);
        check("to_still_busy", 64'(busy), 1);
        tick();
        check("to_done", 64'(done), 64'(5'b00001));
        check("to_err", 64'(err), 1);
        tick();
        check("to_idle", 64'(busy), 0);

        // 3: rotating grant during agent 0 ownership has no effect
        set_req(0, 2'b10, 32'h2000, 32'h0);
        set_req(1, 2'b01, 32'h2100, 32'h0);
        set_req(2, 2'b01, 32'h2200, 32'h0);
        set_req(3, 2'b01, 32'h2300, 32'h0);
        bcast_q.push_back('{cmd: 2'b10, addr: 32'h2000, wdata: 32'h0, src: 3'd0, err: 1'b0});
        done_q.push_back('{done: 5'b00001, data: 32'h5A5A, err: 1'b0});
        gnt = 5'b00001; tick();
        for (int i = 1; i < 4; i++) begin
            gnt = NA'(1) << i;
            tick();
            check("rot_bus_src", 64'(bus_src), 0);
        end
        gnt = '0;
        respond(0, 32'h5A5A);

        // 4: multi-hot grant, lowest index wins with an error pulse
        set_req(1, 2'b00, 32'h3300, 32'h0);
        set_req(4, 2'b11, 32'h4400, 32'hFFFF);
        start_txn(5'b10010, 1, 1'b1, 32'hC0DE, 1'b0);
        respond(3, 32'hC0DE);

        // 5: memory agent WriteBack
        set_req(4, 2'b11, 32'h8000, 32'h1234);
        start_txn(5'b10000, 4, 1'b0, 32'h0042, 1'b0);
        respond(0, 32'h0042);

        // back-to-back grant held high: second capture only after FIN
        set_req(3, 2'b00, 32'h9000, 32'h0);
        start_txn(5'b01000, 3, 1'b0, 32'h77, 1'b0);
        gnt = 5'b01000;
        rsp_valid = 1'b1; rsp_data = 32'h77; tick(); rsp_valid = 1'b0;
        tick();
        check("b2b_idle_after_fin", 64'(busy), 0);
        bcast_q.push_back('{cmd: 2'b00, addr: 32'h9000, wdata: 32'h0, src: 3'd3, err: 1'b0});
        done_q.push_back('{done: 5'b01000, data: 32'h88, err: 1'b0});
        tick();
        gnt = '0;
        tick();
        respond(0, 32'h88);

        // 6: reset mid-WAIT aborts without done, then a new grant is served
        set_req(3, 2'b01, 32'hA000, 32'h0);
        start_txn(5'b01000, 3, 1'b0, 32'h0, 1'b0);
        void'(done_q.pop_back());
        tick();
        rst = 1'b1; tick(); rst = 1'b0;
        check("mrst_busy", 64'(busy), 0);
        check("mrst_bus_valid", 64'(bus_valid), 0);
        check("mrst_bus_addr", 64'(bus_addr), 0);
        check("mrst_bus_src", 64'(bus_src), 0);
        check("mrst_done", 64'(done), 0);
        repeat (2) tick();
        set_req(2, 2'b00, 32'hB000, 32'h0);
        start_txn(5'b00100, 2, 1'b0, 32'hFACE, 1'b0);
        respond(1, 32'hFACE);

        repeat (3) tick();
        check("bcast_q_empty", 64'(bcast_q.size()), 0);
        check("done_q_empty", 64'(done_q.size()), 0);
        check("done_count", 64'(n_done), 8);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/snoop_bus_ctrl.md
Name: snoop_bus_ctrl

Overview:
Shared-bus transaction sequencer that sits directly downstream of the 5-way bus arbiter (4 cache agents plus the memory agent, index 4). In IDLE it latches the one-hot grant and captures the winning agent's command and address. It broadcasts that request on the snoop bus and waits for a response. It then returns the data and a one-cycle done pulse to the owner. It holds bus ownership for the full transaction, independent of the arbiter's per-cycle rotation.

Parameters:
ADDR_W, 32, bus address width
DATA_W, 32, bus data / response width
N_AGENT, 5, number of bus agents (gnt/req index 0..4, memory = 4)
TIMEOUT, 16, max cycles in WAIT before abort (must be >= 2)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
gnt  in  N_AGENT  one-hot grant from arbiter (bit i = gnt_i)
req_cmd  in  2*N_AGENT  per-agent command, agent i at [2i+1:2i]: 00 BusRd, 01 BusRdX, 10 BusUpgr, 11 WriteBack
req_addr  in  ADDR_W*N_AGENT  per-agent address, agent i at [ADDR_W*i +: ADDR_W]
req_wdata  in  DATA_W*N_AGENT  per-agent write data (used for WriteBack only)
bus_valid  out  1  broadcast strobe, exactly one cycle per transaction
bus_cmd  out  2  broadcast command
bus_addr  out  ADDR_W  broadcast address
bus_wdata  out  DATA_W  broadcast write data
bus_src  out  3  index of the owning agent
busy  out  1  high while any transaction is in progress
rsp_valid  in  1  responder (cache or memory) completes the transaction
rsp_data  in  DATA_W  response data
done  out  N_AGENT  one-hot, one-cycle completion pulse to the owner
done_data  out  DATA_W  response data, valid while done != 0
err  out  1  one-cycle pulse, asserted with done on timeout, or for one cycle on a multi-hot grant

Behaviour:
- Reset (synchronous, rst=1 at clk edge): state IDLE; bus_valid=0, bus_cmd=0, bus_addr=0, bus_wdata=0, bus_src=0, busy=0, done=0, done_data=0, err=0; timeout counter=0. Reset mid-transaction aborts it without a done pulse.
- FSM states: IDLE, BCAST, WAIT, FIN.
- IDLE: when gnt != 0, select owner = lowest set bit of gnt. Latch owner's cmd, addr, and wdata into output registers and set bus_src=owner. Next state BCAST.
  - If gnt has more than one bit set, still take the lowest index and pulse err in the same cycle as the BCAST entry.
  - gnt=0: stay in IDLE.
- BCAST: bus_valid=1 for exactly this one cycle; bus_* stable. Next state WAIT; counter cleared to 0.
- WAIT: bus_* held stable, bus_valid=0. Counter increments by 1 each cycle.
  - rsp_valid=1: capture rsp_data into done_data; next state FIN.
  - Else if counter == TIMEOUT-1: done_data=0; next state FIN with the error flag set.
  - rsp_valid outside WAIT is ignored.
- FIN: done[bus_src]=1 for one cycle; err=1 in this cycle if the transaction timed out. Next state IDLE.
  - gnt is not sampled in FIN; the earliest new capture is the cycle after FIN.
- busy = (state != IDLE).
- gnt is ignored in every state except IDLE. Arbiter rotation during a transaction has no effect.
- Latency, no timeout: gnt sampled at edge 0 → bus_valid during cycle 1 → rsp_valid sampled at edge k (k >= 2) → done asserted during cycle k+1.
- Minimum transaction is 4 cycles, IDLE-to-IDLE.
- A BusUpgr completes on rsp_valid like any other command; the data is don't-care for the owner.

Test Plan:
1. Reset, then gnt=5'b00100, cmd2=01, addr2=0x40 → next cycle bus_valid=1, bus_cmd=01, bus_addr=0x40, bus_src=2. Then rsp_valid=1, rsp_data=0xDEAD two cycles later → done=5'b00100, done_data=0xDEAD one cycle after that; busy returns to 0.
2. Timeout: grant agent 0 and never assert rsp_valid → exactly TIMEOUT (16) WAIT cycles, then done=5'b00001 and err=1 in the same cycle, done_data=0.
3. Grant held: gnt rotates 0001→0010→0100→1000 each cycle during a transaction owned by agent 0 → bus_src stays 0, no second bus_valid until after done.
4. Multi-hot: gnt=5'b10010 → owner=1, err pulses once, the transaction completes normally for agent 1.
5. Memory agent: gnt=5'b10000, cmd4=11, wdata4=0x1234 → bus_src=4, bus_wdata=0x1234, done=5'b10000 on rsp_valid.
6. Reset mid-WAIT: rst=1 one cycle during WAIT → all outputs 0 next cycle, no done pulse; a new grant two cycles later is served normally.
